// File: rtl/regfile_wb_sched_if.sv
// One write-back producer channel into the register file scheduler.
// The producer drives the payload and valid. The scheduler returns a combinational grant.
interface regfile_wb_sched_if #(
    parameter int EW = 21,
    parameter int VW = 192
);
    logic          valid;
    logic          dtype;
    logic [2:0]    addr;
    logic [EW-1:0] de;
    logic [VW-1:0] dv;
    logic          ready;

    modport master (output valid, dtype, addr, de, dv, input ready);
    modport slave  (input valid, dtype, addr, de, dv, output ready);
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back arbiter for the scalar/vector register file, plus a busy-bit scoreboard.
// The scoreboard stalls issue on RAW and WAW hazards against outstanding writes.
module regfile_wb_sched #(
    parameter int NREG = 6,
    parameter int EW   = 21,
    parameter int VW   = 192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [2:0]            issue_dst,
    input  logic                  issue_dst_type,
    input  logic                  chk_a1_en,
    input  logic [2:0]            chk_a1,
    input  logic                  chk_a1_type,
    input  logic                  chk_a2_en,
    input  logic [2:0]            chk_a2,
    input  logic                  chk_a2_type,
    output logic                  stall,
    regfile_wb_sched_if.slave     req0,
    regfile_wb_sched_if.slave     req1,
    output logic                  Reg_write,
    output logic                  desType,
    output logic [2:0]            A3,
    output logic [EW-1:0]         wd3e,
    output logic [VW-1:0]         wd3v,
    output logic                  err_addr,
    output logic [NREG-1:0]       busy_e,
    output logic [NREG-1:0]       busy_v
);
    localparam logic [3:0] NREG4 = 4'(NREG);

    logic [NREG-1:0] busy_e_reg, busy_e_next;
    logic [NREG-1:0] busy_v_reg, busy_v_next;
    logic [NREG-1:0] set_e, set_v, clr_e, clr_v;
    logic [NREG-1:0] eff_e, eff_v;
    logic            last_grant_reg, last_grant_next;

    logic            reg_write_reg;
    logic            des_type_reg;
    logic [2:0]      a3_reg;
    logic [EW-1:0]   wd3e_reg;
    logic [VW-1:0]   wd3v_reg;
    logic            err_addr_reg;

    logic            hit1, hit2, dst_busy, accept;
    logic            grant0, grant1, grant_any;
    logic            win_type, win_in_range;
    logic [2:0]      win_addr;
    logic [EW-1:0]   win_de;
    logic [VW-1:0]   win_dv;

    // Out-of-range addresses fall through the loop and read as not busy.
    function automatic logic busy_lookup(input logic [NREG-1:0] be,
                                         input logic [NREG-1:0] bv,
                                         input logic            t,
                                         input logic [2:0]      a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if ({1'b0, a} == 4'(i)) begin
                r = t ? bv[i] : be[i];
            end
        end
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            localparam logic [2:0] IDX = 3'(gi);
            // A launched write that commits at the coming edge no longer counts as a hazard.
            assign clr_e[gi] = reg_write_reg & ~des_type_reg & (a3_reg == IDX);
            assign clr_v[gi] = reg_write_reg &  des_type_reg & (a3_reg == IDX);
            assign set_e[gi] = accept & ~issue_dst_type & (issue_dst == IDX);
            assign set_v[gi] = accept &  issue_dst_type & (issue_dst == IDX);
            // A set on the same edge as a clear wins, because a new writer is outstanding.
            assign busy_e_next[gi] = (busy_e_reg[gi] & ~clr_e[gi]) | set_e[gi];
            assign busy_v_next[gi] = (busy_v_reg[gi] & ~clr_v[gi]) | set_v[gi];
        end
    endgenerate

    assign eff_e = busy_e_reg & ~clr_e;
    assign eff_v = busy_v_reg & ~clr_v;

    always_comb begin
        hit1     = chk_a1_en & busy_lookup(eff_e, eff_v, chk_a1_type, chk_a1);
        hit2     = chk_a2_en & busy_lookup(eff_e, eff_v, chk_a2_type, chk_a2);
        dst_busy = busy_lookup(eff_e, eff_v, issue_dst_type, issue_dst);
        stall    = issue_valid & (hit1 | hit2 | dst_busy);
        accept   = issue_valid & ~stall;
    end

    // Round robin: on a tie, the requester not granted most recently wins.
    always_comb begin
        grant0          = rst & req0.valid & (~req1.valid | last_grant_reg);
        grant1          = rst & req1.valid & (~req0.valid | ~last_grant_reg);
        grant_any       = grant0 | grant1;
        last_grant_next = grant1 ? 1'b1 : (grant0 ? 1'b0 : last_grant_reg);
        win_type        = req0.dtype;
        win_addr        = req0.addr;
        win_de          = req0.de;
        win_dv          = req0.dv;
        if (grant1) begin
            win_type = req1.dtype;
            win_addr = req1.addr;
            win_de   = req1.de;
            win_dv   = req1.dv;
        end
        win_in_range = ({1'b0, win_addr} < NREG4);
    end

    assign req0.ready = grant0;
    assign req1.ready = grant1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_e_reg     <= '0;
            busy_v_reg     <= '0;
            last_grant_reg <= 1'b1;
            reg_write_reg  <= 1'b0;
            err_addr_reg   <= 1'b0;
            des_type_reg   <= 1'b0;
            a3_reg         <= '0;
            wd3e_reg       <= '0;
            wd3v_reg       <= '0;
        end else begin
            busy_e_reg     <= busy_e_next;
            busy_v_reg     <= busy_v_next;
            last_grant_reg <= last_grant_next;
            if (grant_any) begin
                des_type_reg  <= win_type;
                a3_reg        <= win_addr;
                wd3e_reg      <= win_de;
                wd3v_reg      <= win_dv;
                reg_write_reg <= win_in_range;
                err_addr_reg  <= ~win_in_range;
            end else begin
                reg_write_reg <= 1'b0;
                err_addr_reg  <= 1'b0;
            end
        end
    end

    assign Reg_write = reg_write_reg;
    assign desType   = des_type_reg;
    assign A3        = a3_reg;
    assign wd3e      = wd3e_reg;
    assign wd3v      = wd3v_reg;
    assign err_addr  = err_addr_reg;
    assign busy_e    = busy_e_reg;
    assign busy_v    = busy_v_reg;
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler and hazard scoreboard for the scalar/vector register file (6 × 21-bit scalar, 6 × 192-bit vector, 3-bit addresses, single write port). Two producers compete for the one write port: the execution unit (requester 0) and the memory load path (requester 1). The block arbitrates them round-robin and drives the register file write signals from registers. It also keeps a busy bit per destination register and stalls issue on RAW/WAW hazards.

## Interface
Parameters:
- NREG, 6, registers per bank; addresses ≥ NREG are out of range.
- EW, 21, scalar data width.
- VW, 192, vector data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_dst, issue_dst_type  in  3, 1  destination address and bank (0 = scalar, 1 = vector).
- chk_a1_en, chk_a1, chk_a1_type  in  1, 3, 1  source 1 hazard check.
- chk_a2_en, chk_a2, chk_a2_type  in  1, 3, 1  source 2 hazard check.
- stall  out  1  combinational; issue blocked this cycle.
- reqN_valid (N = 0, 1)  in  1  write-back request.
- reqN_type, reqN_addr  in  1, 3  destination bank and address.
- reqN_de, reqN_dv  in  EW, VW  scalar and vector payloads.
- reqN_ready  out  1  combinational grant; the transfer completes when valid & ready.
- Reg_write, desType, A3  out  1, 1, 3  registered register file write controls.
- wd3e, wd3v  out  EW, VW  registered write data.
- err_addr  out  1  registered one-cycle pulse on an out-of-range write-back.
- busy_e, busy_v  out  NREG each  scoreboard state.

## Operation
- Scoreboard:
  - busy_e[i] / busy_v[i] = 1 means a write to that register is outstanding.
  - stall = issue_valid & (hit(chk_a1) | hit(chk_a2) | busy[issue_dst_type][issue_dst]).
  - hit(x) = x_en & busy[x_type][x].
  - A check against an out-of-range address never hits.
- Issue accept: when issue_valid & !stall, set busy[issue_dst_type][issue_dst] at the next edge. An out-of-range issue_dst sets nothing.
- Arbitration:
  - Exactly one valid requester: it is granted.
  - Both valid: the requester not granted most recently wins.
  - last_grant is updated on every grant and resets to 1, so requester 0 wins the first tie.
  - At most one grant per cycle. ready is never asserted without the matching valid.
- Write launch, at the edge where reqN_valid & reqN_ready:
  - Register desType, A3, wd3e, wd3v from the winner.
  - Reg_write = 1 if the address is < NREG. Otherwise Reg_write = 0 and err_addr = 1.
  - Payload of the unused bank is passed through unchanged and is don't-care.
- Busy clear: on the edge where registered Reg_write = 1, clear busy[desType][A3]. This is the same edge on which the register file commits the write.
- Same-edge set and clear of the same bit: set wins, because a new writer is outstanding.
- A grant to a register whose busy bit is 0 is legal. It writes, and the clear is a no-op.

## Timing
- Reset (rst = 0 at an edge) gives:
  - Reg_write = 0, err_addr = 0, desType = 0, A3 = 0, wd3e = 0, wd3v = 0.
  - busy_e = busy_v = 0, last_grant = 1.
  - reqN_ready = 0 while rst = 0.
- Reset mid-operation drops all pending busy bits and any launched write. Producers must re-present.
- Latency:
  - Grant at edge N, so Reg_write is high during cycle N+1.
  - The register file writes at edge N+1, and busy clears at edge N+1.
  - stall deasserts during cycle N+1.
- Reg_write is high for exactly one cycle per grant. Back-to-back grants give back-to-back Reg_write with no bubble.
- stall and ready are purely combinational from registered state and the current inputs. There is no path from stall to ready.

## Test plan
- Reset: hold rst = 0 for 2 cycles with both requesters valid. Required: ready = 0, Reg_write = 0, busy = 0. Release, and req0 is granted first.
- RAW stall: issue to vector dst 3, then issue with chk_a1 = v3. Required: stall = 1. req1 writes v3 at edge N, Reg_write = 1 with A3 = 3 and desType = 1 in cycle N+1, and stall drops in cycle N+1.
- Round-robin: hold both valid for 4 cycles. Required grants 0, 1, 0, 1, and Reg_write high in 4 consecutive cycles.
- Out of range: req0_addr = 7. Required: grant, then Reg_write = 0 and err_addr = 1 for one cycle, with no busy change.
- Set/clear collision: scalar r2 is busy and its write-back commits on the same edge a new issue to r2 is accepted. Required: busy_e[2] remains 1.
- WAW stall: issue to scalar r5 while busy_e[5] = 1. Required: stall = 1 until the r5 commit edge.
